// File: rtl/cordic_result_fifo_slave.sv
// Memory-mapped read slave buffering CORDIC cosine results in a FIFO.
// Word map: 0 DATA (pop), 1 STATUS, 2 CONTROL (flush / clear stickies), 3 ID.
module cordic_result_fifo_slave #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 16,
  parameter logic [31:0] ID_VALUE = 32'hC0510001
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [1:0]        address,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_ID      = 2'd3;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;

  logic              empty_c;
  logic              full_c;
  logic              flush_c;
  logic              clr_sticky_c;
  logic              push_c;
  logic              pop_req_c;
  logic              pop_c;
  logic              ovf_set_c;
  logic              unf_set_c;
  logic [DATA_W-1:0] status_c;
  logic [DATA_W-1:0] rdata_c;

  // Only CONTROL bits [1:0] carry meaning.
  logic unused_wd;
  assign unused_wd = ^writedata[DATA_W-1:2];

  // Access decode and FIFO handshake
  always_comb begin
    empty_c      = (count == '0);
    full_c       = (count == CW'(DEPTH));
    flush_c      = write && (address == ADDR_CONTROL) && writedata[0];
    clr_sticky_c = write && (address == ADDR_CONTROL) && writedata[1];
    in_ready     = !full_c && !flush_c;
    push_c       = in_valid && in_ready;
    pop_req_c    = read && (address == ADDR_DATA);
    pop_c        = pop_req_c && !empty_c;
    ovf_set_c    = in_valid && full_c;
    unf_set_c    = pop_req_c && empty_c;
  end

  // Read mux; every field reflects state before this cycle's updates
  always_comb begin
    status_c           = '0;
    status_c[0]        = empty_c;
    status_c[1]        = full_c;
    status_c[2]        = overflow;
    status_c[3]        = underflow;
    status_c[8 +: CW]  = count;
    rdata_c            = '0;
    case (address)
      ADDR_DATA:    rdata_c = empty_c ? '0 : mem[rd_ptr];
      ADDR_STATUS:  rdata_c = status_c;
      ADDR_CONTROL: rdata_c = '0;
      ADDR_ID:      rdata_c = DATA_W'(ID_VALUE);
      default:      rdata_c = '0;
    endcase
  end

  // Storage is not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (!aclr && push_c) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers, occupancy, sticky flags and registered read port
  always_ff @(posedge clk) begin
    if (aclr) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      if (flush_c) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_c) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop_c) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        count <= count + CW'(push_c) - CW'(pop_c);
      end
      // A same-cycle set beats clear
      overflow      <= (overflow  && !clr_sticky_c) || ovf_set_c;
      underflow     <= (underflow && !clr_sticky_c) || unf_set_c;
      readdatavalid <= read;
      if (read) begin
        readdata <= rdata_c;
      end
    end
  end

endmodule

// File: tb/tb_cordic_result_fifo_slave.sv
// Directed bench for cordic_result_fifo_slave with a queue-based reference model.
module tb_cordic_result_fifo_slave;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 16;
  localparam logic [31:0] ID     = 32'hC0510001;

  logic              clk;
  logic              aclr;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [1:0]        address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  int unsigned n_total;
  int unsigned n_pass;
  bit          started;

  cordic_result_fifo_slave #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ID_VALUE(ID)) dut (
    .clk(clk), .aclr(aclr), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .readdata(readdata), .readdatavalid(readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: contents as a queue, flags as bits
  logic [DATA_W-1:0] q[$];
  bit                m_ovf;
  bit                m_unf;
  logic [DATA_W-1:0] m_rd;
  bit                m_rdv;

  always @(posedge clk) begin
    if (aclr) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_rd = '0; m_rdv = 0;
    end else begin
      bit full, flush, clr, oset, uset;
      full  = (q.size() == DEPTH);
      flush = write && address == 2'd2 && writedata[0];
      clr   = write && address == 2'd2 && writedata[1];
      oset  = in_valid && full;
      uset  = read && address == 2'd0 && q.size() == 0;
      m_rdv = read;
      if (read) begin
        case (address)
          2'd0: m_rd = (q.size() > 0) ? q[0] : '0;
          2'd1: m_rd = DATA_W'(q.size()) * 256 + (m_unf ? 8 : 0) + (m_ovf ? 4 : 0)
                       + (full ? 2 : 0) + (q.size() == 0 ? 1 : 0);
          2'd2: m_rd = '0;
          default: m_rd = ID;
        endcase
      end
      if (read && address == 2'd0 && q.size() > 0) void'(q.pop_front());
      if (in_valid && !full && !flush) q.push_back(in_data);
      if (flush) q.delete();
      m_ovf = (m_ovf && !clr) || oset;
      m_unf = (m_unf && !clr) || uset;
    end
  end

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (started) begin
      chk("model_rdv", DATA_W'(readdatavalid), DATA_W'(m_rdv));
      chk("model_readdata", readdata, m_rd);
      chk("model_in_ready", DATA_W'(in_ready),
          DATA_W'((q.size() != DEPTH) && !(write && address == 2'd2 && writedata[0])));
    end
  end

  task automatic idle_inputs();
    aclr = 0; in_valid = 0; in_data = '0; address = '0; read = 0; write = 0; writedata = '0;
  endtask

  task automatic cyc(input logic rst, input logic iv, input logic [DATA_W-1:0] d,
                     input logic [1:0] a, input logic rd, input logic wr,
                     input logic [DATA_W-1:0] wd);
    aclr = rst; in_valid = iv; in_data = d; address = a; read = rd; write = wr; writedata = wd;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    cyc(0, 1, d, 2'd0, 0, 0, '0);
  endtask

  task automatic rd_reg(input logic [1:0] a, input string name, input logic [DATA_W-1:0] exp);
    cyc(0, 0, '0, a, 1, 0, '0);
    chk(name, readdata, exp);
    chk({name, "_rdv"}, DATA_W'(readdatavalid), 32'd1);
  endtask

  task automatic wr_ctrl(input logic [DATA_W-1:0] wd);
    cyc(0, 0, '0, 2'd2, 0, 1, wd);
  endtask

  initial begin
    n_total = 0; n_pass = 0; started = 0;
    idle_inputs();
    aclr = 1;
    @(posedge clk); #1;
    cyc(1, 0, '0, 2'd0, 0, 0, '0);
    started = 1;
    chk("reset_readdata", readdata, 32'h0);
    chk("reset_rdv", DATA_W'(readdatavalid), 32'h0);
    chk("reset_in_ready", DATA_W'(in_ready), 32'h1);

    rd_reg(2'd3, "id", 32'hC0510001);
    cyc(0, 0, '0, 2'd0, 0, 0, '0);
    chk("rdv_one_cycle", DATA_W'(readdatavalid), 32'h0);
    rd_reg(2'd1, "status_reset", 32'h00000001);

    push(32'h00007FFF); push(32'h00005A82); push(32'h00000000);
    rd_reg(2'd0, "data0", 32'h00007FFF);
    rd_reg(2'd0, "data1", 32'h00005A82);
    rd_reg(2'd0, "data2", 32'h00000000);
    rd_reg(2'd1, "status_empty", 32'h00000001);

    for (int k = 1; k <= 16; k++) push(DATA_W'(k));
    chk("full_in_ready", DATA_W'(in_ready), 32'h0);
    push(32'd17);
    rd_reg(2'd1, "status_full", 32'h00001006);
    rd_reg(2'd2, "control_reads0", 32'h0);
    for (int k = 1; k <= 16; k++) rd_reg(2'd0, "drain", DATA_W'(k));
    rd_reg(2'd1, "status_drained", 32'h00000005);
    wr_ctrl(32'h2);
    rd_reg(2'd1, "status_cleared", 32'h00000001);

    rd_reg(2'd0, "underflow_data", 32'h0);
    rd_reg(2'd1, "status_underflow", 32'h00000009);
    wr_ctrl(32'h2);
    rd_reg(2'd1, "status_unf_cleared", 32'h00000001);

    for (int k = 0; k < 5; k++) push(32'hA000 + DATA_W'(k));
    aclr = 0; in_valid = 1; in_data = 32'hDEAD; address = 2'd2; read = 0; write = 1; writedata = 32'h1;
    #1;
    chk("flush_in_ready", DATA_W'(in_ready), 32'h0);
    @(posedge clk); #1;
    idle_inputs();
    rd_reg(2'd1, "status_flushed", 32'h00000001);
    push(32'h0000BEEF);
    rd_reg(2'd1, "status_one", 32'h00000100);
    rd_reg(2'd0, "after_flush_data", 32'h0000BEEF);

    for (int k = 0; k < 8; k++) push(32'h1000 + DATA_W'(k));
    for (int j = 0; j < 40; j++) begin
      cyc(0, 1, 32'h1000 + DATA_W'(j + 8), 2'd0, 1, 0, '0);
      chk("stream", readdata, 32'h1000 + DATA_W'(j));
    end
    rd_reg(2'd1, "status_count8", 32'h00000800);
    cyc(0, 1, 32'h2000, 2'd0, 1, 0, '0);
    chk("stream_tail", readdata, 32'h1000 + 32'd40);
    cyc(1, 1, 32'h2001, 2'd0, 1, 0, '0);
    chk("reset_no_rdv", DATA_W'(readdatavalid), 32'h0);
    chk("reset_no_rdata", readdata, 32'h0);
    rd_reg(2'd1, "status_after_reset", 32'h00000001);

    cyc(0, 0, '0, 2'd0, 0, 0, '0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cordic_result_fifo_slave.md
Name: cordic_result_fifo_slave

Overview:
- Memory-mapped read slave that buffers results streamed out of the CORDIC cosine pipeline and serves them to the host/msgDMA over a 1-cycle-latency read port.
- Parametrised successor of the single-register readout slave: configurable data width and FIFO depth, a status/control register map, sticky error flags and flush.
- Sits between the CORDIC output stage (stream write side) and the msgDMA/CPU read master.

Parameters:
- DATA_W, 32, width of a CORDIC result word and of readdata/writedata; must be 16..32.
- DEPTH, 16, FIFO entries; power of 2, 2..128.
- ID_VALUE, 32'hC0510001, constant returned at address 3; truncated to DATA_W.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- aclr  in  1  synchronous active-high reset; sampled on rising edge of clk only.
- in_valid  in  1  CORDIC result valid.
- in_data  in  DATA_W  CORDIC result word.
- in_ready  out  1  FIFO can accept in_data this cycle.
- address  in  2  word address: 0 DATA, 1 STATUS, 2 CONTROL, 3 ID.
- read  in  1  read strobe, one access per cycle.
- write  in  1  write strobe.
- writedata  in  DATA_W  write data (CONTROL only).
- readdata  out  DATA_W  registered read data.
- readdatavalid  out  1  high for exactly one cycle, the cycle after an accepted read.

Behaviour:
- Reset (aclr=1 at clock edge): rd/wr pointers 0, count 0, overflow=0, underflow=0, readdata=0, readdatavalid=0. in_ready is combinational and is 1 once count=0. Reset mid-burst discards all FIFO contents and any read in the same cycle (no readdatavalid the next cycle).
- Push: in_valid && in_ready -> store in_data at wr_ptr, wr_ptr+1 mod DEPTH, count+1.
- in_ready = (count != DEPTH) && !flush_now, where flush_now = write && address==2 && writedata[0].
- in_valid while count==DEPTH -> data dropped, overflow sticky set.
- Reads (no waitrequest; read always accepted): readdata/readdatavalid updated on the edge after read.
  - addr 0 DATA: if count>0 return head word, rd_ptr+1 mod DEPTH, count-1; if count==0 return 0, set underflow sticky, pointers unchanged.
  - addr 1 STATUS: bit0 empty (count==0), bit1 full (count==DEPTH), bit2 overflow, bit3 underflow, bits[15:8] count (zero-extended), other bits 0. Value is sampled pre-update (state before the same-cycle push/pop).
  - addr 2 CONTROL: reads 0.
  - addr 3 ID: ID_VALUE.
- Writes: only addr 2 has effect; bit0 flush (pointers and count to 0), bit1 clear overflow and underflow. Writes to 0/1/3 ignored. Simultaneous read and write: both execute; read sees pre-write state.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
- Push and DATA pop while count==0: pop returns 0 and sets underflow; pushed word stored, count becomes 1 (no bypass).
- Push while full and DATA pop same cycle: in_ready=0 (based on registered count), push refused, overflow set if in_valid; count becomes DEPTH-1.
- Flush wins over same-cycle push (in_ready=0) and same-cycle pop (DATA read returns current head, count still goes to 0).
- Sticky set and clear-stickies in the same cycle: set wins.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- Throughput: one push and one pop per cycle sustained; read latency exactly 1 cycle.

Test Plan:
- Reset then read addr 3 and addr 1 -> readdata 32'hC0510001, then 32'h00000001 (empty, count 0); readdatavalid one cycle after each read.
- Push 3 words 0x00007FFF, 0x00005A82, 0x00000000, then 3 DATA reads -> same words in order; STATUS then 0x00000001.
- Push 17 words (DEPTH=16) -> in_ready low after the 16th; STATUS = 0x00001006 (count 16, full, overflow); 16 DATA reads return words 1..16.
- DATA read on empty -> readdata 0, STATUS bit3 set; write CONTROL 0x2 -> STATUS back to 0x00000001.
- Fill 5 words, write CONTROL 0x1 with in_valid held high in the same cycle -> in_ready 0 that cycle, STATUS 0x00000001 after; next push accepted normally.
- 40 cycles of simultaneous push/pop with count held at 8 (pointer wrap, >2 laps) -> read sequence matches push sequence, count stays 8; assert aclr mid-run -> next STATUS read 0x00000001, no spurious readdatavalid.
